// File: rtl/sensor_response_builder_if.sv
// Request, sensor and UART-TX signals of the sensor response builder.
// master = the builder itself; slave = the surrounding decoder/sensor/TX side.
interface sensor_response_builder_if;
  logic       done;
  logic [4:0] sensor_adress;
  logic [2:0] data;
  logic       sensor_start;
  logic [4:0] sensor_sel;
  logic       sensor_done;
  logic       sensor_error;
  logic [7:0] sensor_temperature;
  logic [7:0] sensor_humidity;
  logic       TxBusy;
  logic       TxStart;
  logic [7:0] TxData;
  logic       busy;

  modport master (
    input  done, sensor_adress, data, sensor_done, sensor_error,
           sensor_temperature, sensor_humidity, TxBusy,
    output sensor_start, sensor_sel, TxStart, TxData, busy
  );

  modport slave (
    output done, sensor_adress, data, sensor_done, sensor_error,
           sensor_temperature, sensor_humidity, TxBusy,
    input  sensor_start, sensor_sel, TxStart, TxData, busy
  );
endinterface

// File: rtl/sensor_response_builder.sv
// Validates a decoded request, reads one sensor, and sends a 2-byte
// (code, value) frame to the UART transmitter via a start/busy handshake.
module sensor_response_builder #(
  parameter int NUM_SENSORS    = 1,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input logic                        clk,
  input logic                        rst,
  sensor_response_builder_if.master  bus
);
  localparam int             CW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [5:0]     NS       = 6'(NUM_SENSORS);

  typedef enum logic [3:0] {IDLE, CHECK, START, WAIT, LOAD, TX0, TXW0, TX1, TXW1} state_t;

  state_t        state, state_nx;
  logic          done_q;
  logic [4:0]    addr_q;
  logic [2:0]    cmd_q;
  logic [7:0]    byte0, byte1;
  logic [CW-1:0] cnt;
  logic          seen_busy;
  logic          req, addr_bad, cmd_bad, tmo, txw_done;

  assign req      = bus.done & ~done_q;
  assign addr_bad = {1'b0, addr_q} >= NS;
  assign cmd_bad  = cmd_q > 3'd2;
  assign tmo      = (cnt == CNT_LAST);
  // A TX handshake completes only after busy has been seen high and then low.
  assign txw_done = seen_busy & ~bus.TxBusy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx         = state;
    bus.sensor_start = 1'b0;
    bus.TxStart      = 1'b0;
    case (state)
      IDLE:  if (req) state_nx = CHECK;
      CHECK: state_nx = (addr_bad || cmd_bad) ? LOAD : START;
      START: begin
        bus.sensor_start = 1'b1;
        state_nx         = WAIT;
      end
      WAIT:  if (bus.sensor_done || tmo) state_nx = LOAD;
      LOAD:  state_nx = TX0;
      TX0: if (!bus.TxBusy) begin
        bus.TxStart = 1'b1;
        state_nx    = TXW0;
      end
      TXW0:  if (txw_done) state_nx = TX1;
      TX1: if (!bus.TxBusy) begin
        bus.TxStart = 1'b1;
        state_nx    = TXW1;
      end
      TXW1:  if (txw_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q         <= 1'b0;
      addr_q         <= '0;
      cmd_q          <= '0;
      byte0          <= '0;
      byte1          <= '0;
      cnt            <= '0;
      seen_busy      <= 1'b0;
      bus.sensor_sel <= '0;
      bus.TxData     <= '0;
      bus.busy       <= 1'b0;
    end else begin
      done_q    <= bus.done;
      bus.busy  <= (state_nx != IDLE);
      seen_busy <= (state == TXW0 || state == TXW1) ? (seen_busy | bus.TxBusy) : 1'b0;
      case (state)
        IDLE: if (req) begin
          addr_q <= bus.sensor_adress;
          cmd_q  <= bus.data;
        end
        CHECK: begin
          // Bad address outranks a bad command.
          if (addr_bad) begin
            byte0 <= 8'hFE;
            byte1 <= {3'b000, addr_q};
          end else if (cmd_bad) begin
            byte0 <= 8'hFF;
            byte1 <= {5'b00000, cmd_q};
          end else begin
            bus.sensor_sel <= addr_q;
          end
        end
        START: cnt <= '0;
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (bus.sensor_done) begin
            if (bus.sensor_error) begin
              byte0 <= 8'h1F;
              byte1 <= 8'h00;
            end else begin
              case (cmd_q)
                3'd1:    begin byte0 <= 8'h09; byte1 <= bus.sensor_temperature; end
                3'd2:    begin byte0 <= 8'h08; byte1 <= bus.sensor_humidity;    end
                default: begin byte0 <= 8'h00; byte1 <= 8'h00;                 end
              endcase
            end
          end else if (tmo) begin
            byte0 <= 8'h1E;
            byte1 <= 8'h00;
          end
        end
        LOAD: bus.TxData <= byte0;
        TXW0: if (txw_done) bus.TxData <= byte1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sensor_response_builder.sv
// Directed bench: sensor and UART-TX responders are stepped once per cycle
// alongside the stimulus; frames are captured at the falling edge.
module tb_sensor_response_builder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sensor_response_builder_if bus();

  sensor_response_builder #(.NUM_SENSORS(1), .TIMEOUT_CYCLES(100)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0, fails = 0;
  int cyc = 0, edge_cyc = 0;
  logic [7:0] txq[$];
  int tx_cyc[$];
  int ss_cnt = 0, ss_cyc = 0;
  logic [4:0] ss_sel = '0;
  bit tx_seen = 0, ss_seen = 0, busy_early = 0, hold_done = 0;
  int tx_hold = 3, tx_left = 0, sens_delay = 0, sens_left = 0, poke = -10;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: update responders just after the rising edge, sample at the falling edge.
  task automatic step();
    @(posedge clk); #1;
    cyc++;
    if (tx_seen) begin
      bus.TxBusy = 1'b1;
      tx_left    = tx_hold;
    end else if (tx_left > 0) begin
      tx_left--;
      if (tx_left == 0) bus.TxBusy = 1'b0;
    end
    bus.sensor_done = 1'b0;
    if (ss_seen) sens_left = sens_delay;
    if (sens_left > 0) begin
      sens_left--;
      if (sens_left == 0) bus.sensor_done = 1'b1;
    end
    @(negedge clk);
    tx_seen = bus.TxStart;
    ss_seen = bus.sensor_start;
    if (bus.TxStart) begin
      txq.push_back(bus.TxData);
      tx_cyc.push_back(cyc);
    end
    if (bus.sensor_start) begin
      ss_cnt++;
      ss_cyc = cyc;
      ss_sel = bus.sensor_sel;
    end
  endtask

  task automatic run_frame(input logic [4:0] a, input logic [2:0] c, input int budget, output bit ok);
    int n;
    txq.delete();
    tx_cyc.delete();
    ss_cnt            = 0;
    bus.sensor_adress = a;
    bus.data          = c;
    bus.done          = 1'b1;
    edge_cyc          = cyc;
    step();
    step();
    busy_early = bus.busy;
    if (!hold_done) bus.done = 1'b0;
    n = 0;
    while (!(txq.size() >= 2 && !bus.busy) && n < budget) begin
      if (n == poke) bus.done = 1'b1;
      if (n == poke + 2) bus.done = 1'b0;
      step();
      n++;
    end
    ok = (n < budget);
  endtask

  task automatic check_frame(input string t, input bit ok, input int exp_ss,
                             input logic [7:0] e0, input logic [7:0] e1);
    logic [7:0] g0, g1;
    g0 = (txq.size() > 0) ? txq[0] : 8'hxx;
    g1 = (txq.size() > 1) ? txq[1] : 8'hxx;
    check({t, "_complete"}, 32'(ok), 32'd1);
    check({t, "_busy"}, 32'(busy_early), 32'd1);
    check({t, "_nbytes"}, txq.size(), 32'd2);
    check({t, "_byte0"}, g0, e0);
    check({t, "_byte1"}, g1, e1);
    check({t, "_nstart"}, ss_cnt, exp_ss);
  endtask

  initial begin
    bit ok;
    bus.done = 0; bus.sensor_adress = 0; bus.data = 0;
    bus.sensor_done = 0; bus.sensor_error = 0;
    bus.sensor_temperature = 0; bus.sensor_humidity = 0; bus.TxBusy = 0;

    step(); step();
    check("rst_sensor_start", bus.sensor_start, 0);
    check("rst_sensor_sel", bus.sensor_sel, 0);
    check("rst_txstart", bus.TxStart, 0);
    check("rst_txdata", bus.TxData, 0);
    check("rst_busy", bus.busy, 0);
    rst = 1'b1;
    step(); step();

    // Temperature read, sensor answers 50 cycles after start
    sens_delay = 50; bus.sensor_temperature = 8'h19; bus.sensor_error = 0;
    run_frame(5'd0, 3'b001, 400, ok);
    check_frame("temp", ok, 1, 8'h09, 8'h19);
    check("temp_sel", ss_sel, 0);
    check("temp_start_lat", ss_cyc - edge_cyc, 2);
    check("temp_idle_busy", bus.busy, 0);

    sens_delay = 5; bus.sensor_humidity = 8'h3C;
    run_frame(5'd0, 3'b010, 400, ok);
    check_frame("hum", ok, 1, 8'h08, 8'h3C);

    bus.sensor_error = 1;
    run_frame(5'd0, 3'b000, 400, ok);
    check_frame("stat_err", ok, 1, 8'h1F, 8'h00);
    bus.sensor_error = 0;

    run_frame(5'd5, 3'b001, 400, ok);
    check_frame("bad_addr", ok, 0, 8'hFE, 8'h05);
    check("bad_addr_lat", (tx_cyc.size() > 0) ? tx_cyc[0] - edge_cyc : -1, 3);

    run_frame(5'd0, 3'b110, 400, ok);
    check_frame("bad_cmd", ok, 0, 8'hFF, 8'h06);

    // Timeout: sensor never answers
    sens_delay = 0;
    run_frame(5'd0, 3'b001, 400, ok);
    check_frame("tmo", ok, 1, 8'h1E, 8'h00);
    check("tmo_lat", (tx_cyc.size() > 0) ? tx_cyc[0] - ss_cyc : -1, 102);

    // Answer on the very last timeout cycle: data wins
    sens_delay = 100; bus.sensor_temperature = 8'h55;
    run_frame(5'd0, 3'b001, 400, ok);
    check_frame("tmo_edge", ok, 1, 8'h09, 8'h55);

    // Slow transmitter, done level held high through and after the frame
    sens_delay = 3; tx_hold = 40; hold_done = 1; bus.sensor_temperature = 8'h21;
    run_frame(5'd0, 3'b001, 400, ok);
    check_frame("slow_tx", ok, 1, 8'h09, 8'h21);
    for (int i = 0; i < 30; i++) step();
    check("held_done_nbytes", txq.size(), 2);
    hold_done = 0; bus.done = 0;
    step(); step();

    // Second done edge arrives while the frame is in flight
    tx_hold = 20; poke = 10;
    run_frame(5'd5, 3'b000, 400, ok);
    check_frame("edge_busy", ok, 0, 8'hFE, 8'h05);
    for (int i = 0; i < 30; i++) step();
    check("edge_busy_nbytes", txq.size(), 2);
    poke = -10;

    // Reset while waiting out byte0's handshake
    tx_hold = 40; sens_delay = 3; bus.sensor_temperature = 8'h77;
    txq.delete(); tx_cyc.delete();
    bus.sensor_adress = 0; bus.data = 3'b001; bus.done = 1;
    step(); step(); bus.done = 0;
    for (int i = 0; i < 200 && txq.size() < 1; i++) step();
    for (int i = 0; i < 5; i++) step();
    check("mid_pre_txdata", bus.TxData, 8'h09);
    check("mid_pre_busy", bus.busy, 1);
    rst = 1'b0;
    #1;
    check("mid_sensor_start", bus.sensor_start, 0);
    check("mid_sensor_sel", bus.sensor_sel, 0);
    check("mid_txstart", bus.TxStart, 0);
    check("mid_txdata", bus.TxData, 0);
    check("mid_busy", bus.busy, 0);
    bus.TxBusy = 0; tx_left = 0; tx_seen = 0; sens_left = 0;
    step();
    rst = 1'b1;
    for (int i = 0; i < 60; i++) step();
    check("post_rst_nbytes", txq.size(), 1);
    check("post_rst_busy", bus.busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sensor_response_builder.md
Name: sensor_response_builder

Overview:
- Sits directly downstream of the UART request decoder. Consumes its done / 5-bit sensor address / 3-bit command outputs.
- Validates the request, runs one read on the addressed sensor interface, and formats a 2-byte response frame (code, value).
- Hands the frame byte-by-byte to the UART transmitter through a start/busy handshake.

Parameters:
- NUM_SENSORS, 1: number of implemented sensor addresses; valid range is 0..NUM_SENSORS-1 (at most 32).
- TIMEOUT_CYCLES, 2_000_000: clk cycles to wait for sensor_done before declaring a timeout (minimum 2).

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- done  in  1  request-ready level from the upstream decoder; only its rising edge is a request
- sensor_adress  in  5  requested sensor address; valid with done
- data  in  3  requested command; valid with done
- sensor_start  out  1  one-cycle pulse that starts a sensor read
- sensor_sel  out  5  address of the sensor being read; held stable from START to the end of WAIT
- sensor_done  in  1  one-cycle pulse: read finished, result valid
- sensor_error  in  1  sampled with sensor_done; 1 = sensor fault
- sensor_temperature  in  8  sampled with sensor_done
- sensor_humidity  in  8  sampled with sensor_done
- TxBusy  in  1  UART transmitter busy
- TxStart  out  1  one-cycle pulse: transmit TxData
- TxData  out  8  byte to transmit; held stable until the TX handshake completes
- busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE.
  - Outputs: sensor_start=0, sensor_sel=0, TxStart=0, TxData=0, busy=0.
  - Internal: timeout counter=0, done-edge register=0.
  - A reset mid-frame aborts it immediately; no partial byte is resent after reset.
- Request detect: done is registered each cycle.
  - A request is the cycle where done=1 and the registered done=0.
  - It is accepted only in IDLE; on acceptance, sensor_adress and data are latched.
  - Edges seen outside IDLE are dropped, not queued.
  - A done level that stays high does not retrigger.
- Commands (latched data):
  - 000 status
  - 001 read temperature
  - 010 read humidity
  - 011..111 invalid
- FSM states: IDLE, CHECK, START, WAIT, LOAD, TX0, TXW0, TX1, TXW1.
  - IDLE -> CHECK on an accepted edge.
  - CHECK:
    - Address >= NUM_SENSORS: frame = FE, {000,addr}; go to LOAD.
    - Else invalid command: frame = FF, {00000,cmd}; go to LOAD.
    - Else go to START. The address check takes priority over the command check.
  - START: sensor_start=1 for exactly this cycle; sensor_sel=latched address; clear counter; -> WAIT.
  - WAIT: counter increments each cycle.
    - If sensor_done=1 and sensor_error=1: frame = 1F, 00.
    - If sensor_done=1 and sensor_error=0:
      - status: frame = 00, 00
      - temperature: frame = 09, temperature
      - humidity: frame = 08, humidity
    - Then go to LOAD.
    - Otherwise, when counter reaches TIMEOUT_CYCLES-1 with no sensor_done: frame = 1E, 00; go to LOAD.
    - If sensor_done and the timeout coincide in the same cycle, sensor_done wins.
  - LOAD: TxData = byte0; -> TX0.
  - TX0: wait until TxBusy=0, then TxStart=1 for one cycle; -> TXW0.
  - TXW0: wait for TxBusy=1, then for TxBusy=0; then TxData = byte1; -> TX1.
  - TX1: same rule as TX0; -> TXW1.
  - TXW1: same wait rule as TXW0; then -> IDLE.
- Latency: for an invalid request, TxStart for byte0 is asserted 3 cycles after the accepting edge (CHECK, LOAD, TX0), given TxBusy=0.
- sensor_done pulses outside WAIT are ignored.
- busy is a registered decode of state != IDLE.

Test Plan:
- Read OK: done rising with addr=0, cmd=001; sensor_done 50 cycles after sensor_start with temp=0x19, error=0.
  - Expect one sensor_start pulse with sensor_sel=0, then TX bytes 0x09 then 0x19; busy falls after byte1 completes.
- Humidity / status: cmd=010 with hum=0x3C -> bytes 08, 3C. cmd=000 with error=1 -> bytes 1F, 00.
- Invalid cases: addr=5 with NUM_SENSORS=1 -> bytes FE, 05 and no sensor_start. addr=0, cmd=110 -> bytes FF, 06.
- Timeout: TIMEOUT_CYCLES=100, sensor_done never arrives -> bytes 1E, 00 with TxStart at 100 cycles after sensor_start + 2.
  - Repeat with sensor_done on the final cycle -> data frame is sent, not the timeout frame.
- Handshake / edges:
  - Hold TxBusy=1 for 40 cycles after each TxStart -> exactly 2 TxStart pulses.
  - Keep done high throughout -> no second frame.
  - A second done edge while busy -> ignored.
- Reset mid-frame: assert rst=0 during TXW0 -> all outputs 0 in the same cycle.
  - After release, no TxStart until a new done edge arrives.
